alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered operand-issue stage directly upstream of the 32-bit ALU. Accepts decoded instructions from the decode stage and resolves operand forwarding and immediate selection. Produces the registered ALU control code and operands (`alu_ctl`, `alu_a`, `alu_b`) with a valid/ready handshake. Owns the ID/EX boundary and flags function codes the ALU does not implement.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- `DATA_W`, 32, operand width; must equal the ALU width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: upstream holds a decoded instruction.
- `in_ready` out 1: stage can accept this cycle.
- `in_funct` in 6: function code; 32 add, 34 sub, 36 and, 37 or, 42 slt.
- `in_rs_addr`, `in_rt_addr` in 5: source register numbers.
- `in_rs_data`, `in_rt_data` in DATA_W: register-file read data.
- `in_imm` in 16: immediate field.
- `in_use_imm` in 1: B operand is the extended immediate, not rt.
- `in_imm_zext` in 1: zero-extend the immediate; otherwise sign-extend.
- `in_rd_addr` in 5: destination register, passed through.
- `fwd_ex_valid` in 1, `fwd_ex_addr` in 5, `fwd_ex_data` in DATA_W: producer one stage ahead.
- `fwd_mem_valid` in 1, `fwd_mem_addr` in 5, `fwd_mem_data` in DATA_W: producer two stages ahead.
- `flush` in 1: kill the held instruction and any instruction offered this cycle.
- `out_valid` out 1: `alu_*` outputs hold a live instruction.
- `out_ready` in 1: downstream consumes this cycle.
- `alu_ctl` out 6: control code to the ALU.
- `alu_a`, `alu_b` out DATA_W: operands to the ALU.
- `out_rd_addr` out 5: destination register, registered.
- `illegal_op` out 1: sticky flag, set when an unsupported funct is accepted.

## Operation
- A transfer happens when `in_valid && in_ready`. `in_ready = !out_valid || out_ready`, which is a single-entry pipeline register.
- A operand is resolved by priority:
  - `in_rs_addr` == 0 gives `in_rs_data` unchanged; register 0 is never forwarded.
  - An EX hit (`fwd_ex_valid` and address match) gives `fwd_ex_data`.
  - Otherwise a MEM hit gives `fwd_mem_data`.
  - Otherwise `in_rs_data`.
- B operand: if `in_use_imm`, it is {16{imm[15]&~zext}, imm}. Otherwise it is rt resolved with the same priority as rs.
- Forwarding is sampled in the transfer cycle only. Held outputs do not re-forward.
- Funct 32/34/36/37/42 pass unchanged to `alu_ctl`. Any other funct is issued as `alu_ctl` = 32 (add) and sets `illegal_op`.
- `illegal_op` clears only on reset.
- Flush:
  - On a flush edge, `out_valid` becomes 0 and any concurrent transfer is discarded.
  - Flush outranks transfer, and `illegal_op` is not set by a discarded instruction.
  - Data registers may hold stale values while `out_valid` = 0.
- Two-state control, EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1):
  - EMPTY to FULL: on transfer without flush.
  - FULL stays FULL: on transfer plus consume, or no consume.
  - FULL to EMPTY: on consume without transfer, or on flush.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible on `alu_*` after edge N.
- Throughput is one instruction per cycle when `out_ready` is held at 1.
- Backpressure: while FULL and `out_ready` = 0, all outputs hold stable and `in_ready` = 0.
- `in_ready` is combinational from `out_valid` and `out_ready`. No other input reaches any output combinationally.
- Reset values: `out_valid` 0, `alu_ctl` 0, `alu_a` 0, `alu_b` 0, `out_rd_addr` 0, `illegal_op` 0.
- `in_ready` is 1 during and after reset.
- If reset asserts mid-operation, the held instruction is lost. The first transfer after release issues normally.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding muxes present as described.
- Not defined:
  - `fwd_*` inputs are ignored and operands come straight from register data and immediate.
  - Hazards are then the decode stage's responsibility.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs. Required: all outputs 0, `in_ready` = 1. Release, then offer funct 32, rs_data 5, rt_data 7. Required: next cycle `alu_ctl` = 32, A = 5, B = 7, `out_valid` = 1.
- Immediate: funct 42, `in_use_imm`, imm 0xFFFE. With zext = 0, B = 0xFFFFFFFE. With zext = 1, B = 0x0000FFFE.
- Forward priority (macro on): rs = 3, EX addr 3 data 0xAA, MEM addr 3 data 0xBB. Required: A = 0xAA. With the EX hit removed, A = 0xBB. With rs = 0 and both units pointing at 0, A = `in_rs_data`. With the macro off, A = `in_rs_data` in every case.
- Backpressure: stream 4 instructions while `out_ready` toggles 1,0,0,1,1. Required: no loss or duplication, outputs stable while stalled, `in_ready` low exactly in the stall cycles.
- Flush: FULL with `out_ready` = 0; assert flush together with `in_valid` carrying funct 0x3F. Required: next cycle `out_valid` = 0 and `illegal_op` = 0.
- Illegal op: accept funct 0x3F without flush. Required: `alu_ctl` = 32, `illegal_op` = 1. Then accept funct 34. Required: `illegal_op` stays 1 until reset.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-issue register ahead of the ALU: forwarding, immediate extension, funct legality (forwarding under ALU_ISSUE_FWD_EN).
// Latency 1 cycle; one instruction per cycle when out_ready is held high.
// Backpressure: while FULL and out_ready is low, in_ready drops and all outputs hold.
module alu_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_rs_addr,
    input  logic [4:0]        in_rt_addr,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [15:0]       in_imm,
    input  logic              in_use_imm,
    input  logic              in_imm_zext,
    input  logic [4:0]        in_rd_addr,
    input  logic              fwd_ex_valid,
    input  logic [4:0]        fwd_ex_addr,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic              fwd_mem_valid,
    input  logic [4:0]        fwd_mem_addr,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        alu_ctl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        out_rd_addr,
    output logic              illegal_op
);

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t state;

    logic              xfer;
    logic              legal;
    logic [5:0]        ctl_nxt;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_nxt;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;

`ifdef ALU_ISSUE_FWD_EN
    // Register 0 is hardwired, so it never takes a forwarded value.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] regd,
        input logic              ex_v,
        input logic [4:0]        ex_a,
        input logic [DATA_W-1:0] ex_d,
        input logic              mem_v,
        input logic [4:0]        mem_a,
        input logic [DATA_W-1:0] mem_d
    );
        logic [DATA_W-1:0] r;
        r = regd;
        if (addr != 5'd0) begin
            if (ex_v && ex_a == addr)
                r = ex_d;
            else if (mem_v && mem_a == addr)
                r = mem_d;
        end
        return r;
    endfunction

    always_comb begin
        rs_val = resolve(in_rs_addr, in_rs_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                         fwd_mem_valid, fwd_mem_addr, fwd_mem_data);
        rt_val = resolve(in_rt_addr, in_rt_data, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                         fwd_mem_valid, fwd_mem_addr, fwd_mem_data);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{in_rs_addr, in_rt_addr, fwd_ex_valid, fwd_ex_addr, fwd_ex_data,
                          fwd_mem_valid, fwd_mem_addr, fwd_mem_data};

    always_comb begin
        rs_val = in_rs_data;
        rt_val = in_rt_data;
    end
`endif

    always_comb begin
        imm_ext = {{(DATA_W-16){in_imm[15] & ~in_imm_zext}}, in_imm};
        b_nxt   = in_use_imm ? imm_ext : rt_val;
        legal   = (in_funct == F_ADD) || (in_funct == F_SUB) || (in_funct == F_AND) ||
                  (in_funct == F_OR)  || (in_funct == F_SLT);
        ctl_nxt = legal ? in_funct : F_ADD;
    end

    // Flush outranks transfer: a killed instruction neither loads nor flags illegal_op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            alu_ctl     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            out_rd_addr <= '0;
            illegal_op  <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (xfer) begin
            state       <= FULL;
            alu_ctl     <= ctl_nxt;
            alu_a       <= rs_val;
            alu_b       <= b_nxt;
            out_rd_addr <= in_rd_addr;
            if (!legal)
                illegal_op <= 1'b1;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage with a queue-based scoreboard.
module tb_alu_issue_stage;

    typedef struct {
        logic        vld;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
        logic [15:0] imm;
        logic        use_imm, zext;
        logic        exv, memv;
        logic [4:0]  exa, mema;
        logic [31:0] exd, memd;
    } ins_t;

    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic [31:0] in_rs_data, in_rt_data;
    logic [15:0] in_imm;
    logic        in_use_imm, in_imm_zext;
    logic        fwd_ex_valid, fwd_mem_valid;
    logic [4:0]  fwd_ex_addr, fwd_mem_addr;
    logic [31:0] fwd_ex_data, fwd_mem_data;
    logic        flush, out_valid, out_ready;
    logic [5:0]  alu_ctl;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  out_rd_addr;
    logic        illegal_op;

    int   vectors = 0;
    int   errors  = 0;
    exp_t q[$];
    logic exp_ill = 1'b0;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_imm_zext(in_imm_zext), .in_rd_addr(in_rd_addr),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_addr(fwd_ex_addr), .fwd_ex_data(fwd_ex_data),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_addr(fwd_mem_addr), .fwd_mem_data(fwd_mem_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
        .alu_a(alu_a), .alu_b(alu_b), .out_rd_addr(out_rd_addr), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand selection, straight from the forwarding priority rules.
    function automatic logic [31:0] operand(input ins_t i, input logic [4:0] addr, input logic [31:0] regd);
`ifdef ALU_ISSUE_FWD_EN
        if (addr == 0) return regd;
        if (i.exv && i.exa == addr) return i.exd;
        if (i.memv && i.mema == addr) return i.memd;
`endif
        return regd;
    endfunction

    function automatic exp_t model(input ins_t i);
        exp_t e;
        e.ill = !(i.funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
        e.ctl = e.ill ? 6'd32 : i.funct;
        e.a   = operand(i, i.rs, i.rsd);
        if (!i.use_imm)   e.b = operand(i, i.rt, i.rtd);
        else if (i.zext)  e.b = {16'h0000, i.imm};
        else              e.b = {{16{i.imm[15]}}, i.imm};
        e.rd  = i.rd;
        return e;
    endfunction

    function automatic ins_t current();
        ins_t i;
        i.vld = in_valid; i.funct = in_funct; i.rs = in_rs_addr; i.rt = in_rt_addr;
        i.rd = in_rd_addr; i.rsd = in_rs_data; i.rtd = in_rt_data; i.imm = in_imm;
        i.use_imm = in_use_imm; i.zext = in_imm_zext;
        i.exv = fwd_ex_valid; i.exa = fwd_ex_addr; i.exd = fwd_ex_data;
        i.memv = fwd_mem_valid; i.mema = fwd_mem_addr; i.memd = fwd_mem_data;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        logic [5:0] legal_f[5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        i.vld = 1'b1;
        i.funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 4)];
        i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom); i.rsd = $urandom; i.rtd = $urandom; i.imm = 16'($urandom);
        i.use_imm = 1'($urandom); i.zext = 1'($urandom);
        i.exv = 1'($urandom); i.exa = 5'($urandom_range(0, 3)); i.exd = $urandom;
        i.memv = 1'($urandom); i.mema = 5'($urandom_range(0, 3)); i.memd = $urandom;
        return i;
    endfunction

    function automatic ins_t plain(input logic [5:0] f, input logic [31:0] rsd, input logic [31:0] rtd);
        ins_t i;
        i = rand_ins();
        i.funct = f; i.rsd = rsd; i.rtd = rtd; i.use_imm = 1'b0;
        i.exv = 1'b0; i.memv = 1'b0;
        return i;
    endfunction

    task automatic drive(input ins_t i, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid = i.vld; in_funct = i.funct; in_rs_addr = i.rs; in_rt_addr = i.rt;
        in_rd_addr = i.rd; in_rs_data = i.rsd; in_rt_data = i.rtd; in_imm = i.imm;
        in_use_imm = i.use_imm; in_imm_zext = i.zext;
        fwd_ex_valid = i.exv; fwd_ex_addr = i.exa; fwd_ex_data = i.exd;
        fwd_mem_valid = i.memv; fwd_mem_addr = i.mema; fwd_mem_data = i.memd;
        out_ready = ordy; flush = fl;
    endtask

    task automatic idle(input logic ordy);
        ins_t i;
        i = rand_ins();
        i.vld = 1'b0;
        drive(i, ordy, 1'b0);
    endtask

    // Issue one instruction, then look at the outputs one cycle later.
    task automatic issue_and_look(input ins_t i);
        drive(i, 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(rand_ins(), 1'($urandom), 1'($urandom));
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_alu", {alu_ctl, alu_b[9:0], alu_a[10:0], out_rd_addr}, 32'd0);
            chk("rst_illegal", 32'(illegal_op), 32'd0);
        end
        idle(1'b1);
        rst_n = 1'b1;
    endtask

    // Scoreboard: compare the held instruction against the queue head, then
    // retire it on consume and enqueue whatever the model says transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_ill = 1'b0;
        end else begin
            int   n;
            exp_t e;
            n = q.size();
            chk("out_valid", 32'(out_valid), 32'(n != 0));
            chk("in_ready", 32'(in_ready), 32'((n == 0) || out_ready));
            chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
            if (n != 0 && out_valid) begin
                chk("alu_ctl", 32'(alu_ctl), 32'(q[0].ctl));
                chk("alu_a", alu_a, q[0].a);
                chk("alu_b", alu_b, q[0].b);
                chk("out_rd_addr", 32'(out_rd_addr), 32'(q[0].rd));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (n != 0 && out_ready) void'(q.pop_front());
                if (in_valid && ((n == 0) || out_ready)) begin
                    e = model(current());
                    q.push_back(e);
                    if (e.ill) exp_ill = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        ins_t i;
        logic [31:0] exp_a;
        logic pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int sent, cyc;

        rst_n = 1'b0;
        i = rand_ins();
        drive(i, 1'b0, 1'b0);
        do_reset();

        // First transfer after reset.
        issue_and_look(plain(6'd32, 32'd5, 32'd7));
        chk("first_ctl", 32'(alu_ctl), 32'd32);
        chk("first_a", alu_a, 32'd5);
        chk("first_b", alu_b, 32'd7);
        chk("first_valid", 32'(out_valid), 32'd1);

        // Immediate extension.
        i = plain(6'd42, 32'd1, 32'd2);
        i.use_imm = 1'b1; i.imm = 16'hFFFE; i.zext = 1'b0;
        issue_and_look(i);
        chk("imm_sext", alu_b, 32'hFFFF_FFFE);
        i.zext = 1'b1;
        issue_and_look(i);
        chk("imm_zext", alu_b, 32'h0000_FFFE);

        // Forwarding priority.
        i = plain(6'd32, 32'h11, 32'h22);
        i.rs = 5'd3; i.exv = 1'b1; i.exa = 5'd3; i.exd = 32'hAA;
        i.memv = 1'b1; i.mema = 5'd3; i.memd = 32'hBB;
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'hAA;
`else
        exp_a = 32'h11;
`endif
        issue_and_look(i);
        chk("fwd_ex", alu_a, exp_a);
        i.exv = 1'b0;
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'hBB;
`endif
        issue_and_look(i);
        chk("fwd_mem", alu_a, exp_a);
        i.rs = 5'd0; i.exv = 1'b1; i.exa = 5'd0; i.mema = 5'd0;
        issue_and_look(i);
        chk("fwd_r0", alu_a, 32'h11);

        // Backpressure stream.
        sent = 0;
        cyc = 0;
        while (sent < 4 && cyc < 20) begin
            drive(plain(6'd36, 32'(sent + 100), 32'(sent + 200)), (cyc < 8) ? pat[cyc] : 1'b1, 1'b0);
            #1;
            if (in_ready) sent++;
            cyc++;
        end
        chk("bp_sent", 32'(sent), 32'd4);
        repeat (3) idle(1'b1);

        // Flush while stalled, and flush against a live transfer.
        drive(plain(6'd34, 32'd9, 32'd8), 1'b0, 1'b0);
        idle(1'b0);
        drive(plain(6'h3F, 32'd1, 32'd1), 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_illegal", 32'(illegal_op), 32'd0);
        drive(plain(6'h3F, 32'd1, 32'd1), 1'b1, 1'b1);
        idle(1'b1);
        @(negedge clk);
        chk("flush_xfer_valid", 32'(out_valid), 32'd0);
        chk("flush_xfer_illegal", 32'(illegal_op), 32'd0);

        // Sticky illegal op.
        issue_and_look(plain(6'h3F, 32'd4, 32'd4));
        chk("illegal_ctl", 32'(alu_ctl), 32'd32);
        chk("illegal_set", 32'(illegal_op), 32'd1);
        issue_and_look(plain(6'd34, 32'd4, 32'd4));
        chk("illegal_sticky", 32'(illegal_op), 32'd1);
        chk("sub_ctl", 32'(alu_ctl), 32'd34);

        // Reset mid-operation drops the held instruction and the flag.
        drive(plain(6'd37, 32'd6, 32'd6), 1'b0, 1'b0);
        do_reset();
        issue_and_look(plain(6'd37, 32'd3, 32'd12));
        chk("post_rst_a", alu_a, 32'd3);
        chk("post_rst_illegal", 32'(illegal_op), 32'd0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            i = rand_ins();
            i.vld = 1'($urandom_range(0, 3) != 0);
            drive(i, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        repeat (3) idle(1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
